// File: rtl/clk_div_monitor_pkg.sv
// Shared types and constants for the clk_div_monitor block.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } mon_state_e;

    // Width of the consecutive-match counter (LOCK_COUNT is at most 15).
    localparam int unsigned MATCH_W       = 4;
    localparam int unsigned CNT_W_DEFAULT = 8;

    // Saturation value of a w-bit period counter.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned CNT_MAX = cnt_max(CNT_W_DEFAULT);

endpackage

// File: rtl/clk_div_monitor_if.sv
// Monitor bus: clock under test and clear in, status out to the CSR block.
interface clk_div_monitor_if #(
    parameter int unsigned CNT_W = clk_mon_pkg::CNT_W_DEFAULT
);
    logic             clk_div;
    logic             err_clr;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             lock_err;
    logic             stuck_err;
    logic             duty_err;

    modport master (
        output clk_div, err_clr,
        input  period, period_valid, locked, lock_err, stuck_err, duty_err
    );

    modport slave (
        input  clk_div, err_clr,
        output period, period_valid, locked, lock_err, stuck_err, duty_err
    );
endinterface

// File: rtl/clk_div_monitor_sampler.sv
// Samples clk_div on clk_in and detects its rising edge.
// With CLK_MON_DUTY_CHECK_EN defined, a negedge sampler is added for the
// half-cycle high-time measurement; otherwise s_neg is tied low.
module clk_div_sampler (
    input  logic clk_in,
    input  logic reset,
    input  logic clk_div,
    output logic rise,
    output logic s_pos,
    output logic s_neg
);
    logic s_pos_q, s_pos_d;
    logic s_dly_q, s_dly_d;

    // Two-stage posedge history of clk_div.
    always_comb begin
        s_pos_d = clk_div;
        s_dly_d = s_pos_q;
    end

    // Posedge sample registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            s_pos_q <= 1'b0;
            s_dly_q <= 1'b0;
        end else begin
            s_pos_q <= s_pos_d;
            s_dly_q <= s_dly_d;
        end
    end

    assign rise  = s_pos_q & ~s_dly_q;
    assign s_pos = s_pos_q;

`ifdef CLK_MON_DUTY_CHECK_EN
    logic s_neg_q, s_neg_d;

    // Negedge sample of clk_div, giving the second half-cycle of each period.
    always_comb begin
        s_neg_d = clk_div;
    end

    // Negedge sample register with its own synchronous reset.
    always_ff @(negedge clk_in) begin
        if (reset) begin
            s_neg_q <= 1'b0;
        end else begin
            s_neg_q <= s_neg_d;
        end
    end

    assign s_neg = s_neg_q;
`else
    assign s_neg = 1'b0;
`endif

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures the clk_div period in clk_in cycles,
// locks after LOCK_COUNT consecutive periods equal to DIV, and raises
// sticky lock-loss / stuck-clock errors.
// Optional duty-cycle check enabled by defining CLK_MON_DUTY_CHECK_EN.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned DIV        = 3,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic           clk_in,
    input  logic           reset,
    clk_div_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0]   CNT_SAT = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0]   DIV_C   = CNT_W'(DIV);
    localparam logic [MATCH_W-1:0] LOCK_C  = MATCH_W'(LOCK_COUNT);

    logic rise, s_pos, s_neg;

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MATCH_W-1:0] match_q, match_d, match_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             lock_err_q, lock_err_d;
    logic             stuck_err_q, stuck_err_d;
    logic             lock_ev, stuck_ev;

    clk_div_sampler u_sampler (
        .clk_in  (clk_in),
        .reset   (reset),
        .clk_div (bus.clk_div),
        .rise    (rise),
        .s_pos   (s_pos),
        .s_neg   (s_neg)
    );

    // Period counter, lock FSM and sticky error next-state logic.
    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        period_d  = period_q;
        pv_d      = 1'b0;
        locked_d  = locked_q;
        lock_ev   = 1'b0;
        stuck_ev  = 1'b0;
        match_inc = match_q + MATCH_W'(1);

        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                // First edge only starts the count; there is no period yet.
                if (rise) begin
                    state_d = ACQ;
                    match_d = '0;
                end
            end
            ACQ: begin
                if (rise) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    if (cnt_q == DIV_C) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_C) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end else if (cnt_q == CNT_SAT) begin
                    stuck_ev = 1'b1;
                    locked_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    if (cnt_q != DIV_C) begin
                        lock_ev  = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                        state_d  = ACQ;
                    end
                end else if (cnt_q == CNT_SAT) begin
                    stuck_ev = 1'b1;
                    locked_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                locked_d = 1'b0;
            end
        endcase

        // A new error event outranks a simultaneous clear.
        lock_err_d  = (lock_err_q  & ~bus.err_clr) | lock_ev;
        stuck_err_d = (stuck_err_q & ~bus.err_clr) | stuck_ev;
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            match_q     <= '0;
            period_q    <= '0;
            pv_q        <= 1'b0;
            locked_q    <= 1'b0;
            lock_err_q  <= 1'b0;
            stuck_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            match_q     <= match_d;
            period_q    <= period_d;
            pv_q        <= pv_d;
            locked_q    <= locked_d;
            lock_err_q  <= lock_err_d;
            stuck_err_q <= stuck_err_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.locked       = locked_q;
    assign bus.lock_err     = lock_err_q;
    assign bus.stuck_err    = stuck_err_q;

`ifdef CLK_MON_DUTY_CHECK_EN
    // High time is counted in half-cycles, so a period can reach 2*CNT_MAX.
    localparam int unsigned       HIGH_W = CNT_W + 1;
    localparam logic [HIGH_W-1:0] HIGH_EXP = HIGH_W'(DIV);

    logic [HIGH_W-1:0] high_cnt_q, high_cnt_d;
    logic              duty_err_q, duty_err_d;
    logic              duty_ev;

    // High-time accumulation per period and duty check on each locked edge.
    always_comb begin
        high_cnt_d = (rise ? '0 : high_cnt_q) + HIGH_W'(s_pos) + HIGH_W'(s_neg);
        duty_ev    = rise && (state_q == LOCKED) && (high_cnt_q != HIGH_EXP);
        duty_err_d = (duty_err_q & ~bus.err_clr) | duty_ev;
    end

    // Duty-check registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            high_cnt_q <= '0;
            duty_err_q <= 1'b0;
        end else begin
            high_cnt_q <= high_cnt_d;
            duty_err_q <= duty_err_d;
        end
    end

    assign bus.duty_err = duty_err_q;
`else
    logic unused_samples;
    assign unused_samples = &{1'b0, s_pos, s_neg};
    assign bus.duty_err   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor (DIV=3, CNT_W=8, LOCK_COUNT=4).
module tb_clk_div_monitor;
    localparam int unsigned DIV        = 3;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned LOCK_COUNT = 4;
    localparam int          CMAX       = (1 << CNT_W) - 1;
    localparam int          MAXC       = 30000;
`ifdef CLK_MON_DUTY_CHECK_EN
    localparam bit DUTY_EN = 1'b1;
`else
    localparam bit DUTY_EN = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    clk_div_monitor_if #(.CNT_W(CNT_W)) bus ();

    clk_div_monitor #(
        .DIV        (DIV),
        .CNT_W      (CNT_W),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Half-cycle history of the clock under test as seen by the monitor:
    // ha[c] is the level at posedge c, hb[c] the level at the following negedge.
    bit ha [MAXC];
    bit hb [MAXC];
    int p = 2;

    // Reference model state, expressed in terms of rise timestamps.
    bit m_idle = 1'b1;
    int m_last = 0;
    int m_match = 0;
    bit m_locked = 1'b0, m_lerr = 1'b0, m_serr = 1'b0, m_derr = 1'b0, m_pv = 1'b0;
    int m_period = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, p);
        end
    endtask

    task automatic model_step(input bit clr, input bit rst);
        bit rise, ev_l, ev_s, ev_d;
        int d, hsum;
        if (rst) begin
            m_idle = 1'b1; m_last = 0; m_match = 0; m_locked = 1'b0;
            m_lerr = 1'b0; m_serr = 1'b0; m_derr = 1'b0; m_pv = 1'b0; m_period = 0;
            return;
        end
        rise = ha[p-1] && !ha[p-2];
        ev_l = 1'b0; ev_s = 1'b0; ev_d = 1'b0;
        m_pv = 1'b0;
        if (m_idle) begin
            if (rise) begin
                m_idle = 1'b0; m_last = p; m_match = 0;
            end
        end else if (rise) begin
            d = p - m_last;
            m_pv = 1'b1;
            m_period = d;
            if (m_locked) begin
                hsum = 0;
                for (int c = m_last - 1; c <= p - 2; c++) hsum += int'(ha[c]) + int'(hb[c]);
                if (DUTY_EN && hsum != DIV) ev_d = 1'b1;
                if (d != DIV) begin
                    ev_l = 1'b1; m_locked = 1'b0; m_match = 0;
                end
            end else if (d == DIV) begin
                m_match++;
                if (m_match == LOCK_COUNT) m_locked = 1'b1;
            end else begin
                m_match = 0;
            end
            m_last = p;
        end else if (p - m_last >= CMAX) begin
            ev_s = 1'b1; m_locked = 1'b0; m_idle = 1'b1;
        end
        m_lerr = (m_lerr && !clr) || ev_l;
        m_serr = (m_serr && !clr) || ev_s;
        m_derr = (m_derr && !clr) || ev_d;
    endtask

    task automatic compare_model();
        chk("model_period", int'(bus.period), m_period);
        chk("model_period_valid", int'(bus.period_valid), int'(m_pv));
        chk("model_locked", int'(bus.locked), int'(m_locked));
        chk("model_lock_err", int'(bus.lock_err), int'(m_lerr));
        chk("model_stuck_err", int'(bus.stuck_err), int'(m_serr));
        chk("model_duty_err", int'(bus.duty_err), int'(m_derr));
    endtask

    // One clk_in cycle: a is seen at the posedge, b at the following negedge.
    task automatic cyc(input bit a, input bit b, input bit clr, input bit rst);
        @(negedge clk_in);
        #1;
        bus.clk_div = a;
        bus.err_clr = clr;
        reset       = rst;
        @(posedge clk_in);
        p++;
        if (p >= MAXC - 1) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", p, MAXC - 1);
            $fatal(1);
        end
        ha[p] = rst ? 1'b0 : a;
        #1;
        model_step(clr, rst);
        compare_model();
        bus.clk_div = b;
        hb[p] = rst ? 1'b0 : b;
    endtask

    // One clk_div period of d cycles, high for hi half-cycles from its start.
    task automatic period_t(input int d, input int hi, input int clr_at);
        for (int i = 0; i < d; i++) cyc((2*i) < hi, (2*i+1) < hi, i == clr_at, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // A rising edge that closes the last listed period, plus one cycle so
    // its measurement is visible.
    task automatic close_period();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        int n;
        int per [8];
        int hi_fixed;
        bit e_locked;
        bit e_lerr;
        int e_period;
        bit e_duty;
    } scn_t;

    scn_t tbl [10];

    initial begin : main
        int first_stuck;
        int d, hi, clr_at, r;

        bus.clk_div = 1'b0;
        bus.err_clr = 1'b0;

        tbl[0] = '{4, '{3,3,3,3,0,0,0,0}, 0, 1'b1, 1'b0, 3, 1'b0};
        tbl[1] = '{7, '{3,3,2,3,3,3,3,0}, 0, 1'b1, 1'b0, 3, 1'b0};
        tbl[2] = '{3, '{3,3,3,0,0,0,0,0}, 0, 1'b0, 1'b0, 3, 1'b0};
        tbl[3] = '{5, '{3,3,3,3,4,0,0,0}, 0, 1'b0, 1'b1, 4, 1'b1};
        tbl[4] = '{8, '{3,3,3,3,4,3,3,3}, 0, 1'b0, 1'b1, 3, 1'b1};
        tbl[5] = '{5, '{5,5,5,5,5,0,0,0}, 0, 1'b0, 1'b0, 5, 1'b0};
        tbl[6] = '{7, '{3,3,3,3,3,2,3,0}, 0, 1'b0, 1'b1, 3, 1'b1};
        tbl[7] = '{5, '{3,3,3,3,3,0,0,0}, 2, 1'b1, 1'b0, 3, 1'b1};
        tbl[8] = '{4, '{2,2,2,2,0,0,0,0}, 0, 1'b0, 1'b0, 2, 1'b0};
        tbl[9] = '{1, '{3,0,0,0,0,0,0,0}, 0, 1'b0, 1'b0, 3, 1'b0};

        // Reset state.
        do_reset();
        chk("reset_period", int'(bus.period), 0);
        chk("reset_locked", int'(bus.locked), 0);
        chk("reset_errors", int'({bus.lock_err, bus.stuck_err, bus.duty_err}), 0);

        // Table-driven period patterns, each from reset.
        for (int s = 0; s < 10; s++) begin
            do_reset();
            for (int k = 0; k < tbl[s].n; k++) begin
                d  = tbl[s].per[k];
                hi = (tbl[s].hi_fixed != 0) ? tbl[s].hi_fixed : d;
                period_t(d, hi, -1);
            end
            close_period();
            chk($sformatf("tbl%0d_period_valid", s), int'(bus.period_valid), 1);
            chk($sformatf("tbl%0d_period", s), int'(bus.period), tbl[s].e_period);
            chk($sformatf("tbl%0d_locked", s), int'(bus.locked), int'(tbl[s].e_locked));
            chk($sformatf("tbl%0d_lock_err", s), int'(bus.lock_err), int'(tbl[s].e_lerr));
            chk($sformatf("tbl%0d_stuck_err", s), int'(bus.stuck_err), 0);
            chk($sformatf("tbl%0d_duty_err", s), int'(bus.duty_err), int'(tbl[s].e_duty && DUTY_EN));
        end

        // Stuck clock after lock, then restart and relock.
        do_reset();
        for (int k = 0; k < 4; k++) period_t(3, 3, -1);
        close_period();
        chk("stuck_prelocked", int'(bus.locked), 1);
        first_stuck = -1;
        for (int k = 1; k <= 300; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.stuck_err && first_stuck < 0) first_stuck = k;
        end
        chk("stuck_latency", first_stuck, CMAX);
        chk("stuck_locked", int'(bus.locked), 0);
        chk("stuck_period_kept", int'(bus.period), 3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("stuck_restart_no_pv", int'(bus.period_valid), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) period_t(3, 3, -1);
        close_period();
        chk("stuck_relocked", int'(bus.locked), 1);
        chk("stuck_err_sticky", int'(bus.stuck_err), 1);

        // Lock error with a simultaneous clear, then a quiet clear.
        do_reset();
        for (int k = 0; k < 4; k++) period_t(3, 3, -1);
        period_t(4, 4, -1);
        period_t(3, 3, 1);
        chk("clr_race_lock_err", int'(bus.lock_err), 1);
        chk("clr_race_duty_err", int'(bus.duty_err), int'(DUTY_EN));
        chk("clr_race_locked", int'(bus.locked), 0);
        period_t(3, 3, 1);
        chk("clr_quiet_lock_err", int'(bus.lock_err), 0);
        chk("clr_quiet_duty_err", int'(bus.duty_err), 0);

        // Short high time once locked, cleared in the same cycle it fails.
        do_reset();
        for (int k = 0; k < 5; k++) period_t(3, 2, -1);
        period_t(3, 3, 1);
        chk("duty_race_duty_err", int'(bus.duty_err), int'(DUTY_EN));
        chk("duty_race_locked", int'(bus.locked), 1);
        chk("duty_race_lock_err", int'(bus.lock_err), 0);

        // Reset while locked with lock_err set.
        do_reset();
        for (int k = 0; k < 4; k++) period_t(3, 3, -1);
        period_t(4, 3, -1);
        for (int k = 0; k < 4; k++) period_t(3, 3, -1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_pre_locked", int'(bus.locked), 1);
        chk("rst_pre_lock_err", int'(bus.lock_err), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_all_outputs", int'({bus.period, bus.period_valid, bus.locked,
                                     bus.lock_err, bus.stuck_err, bus.duty_err}), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_first_rise_no_pv", int'(bus.period_valid), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized periods, duty, clears, stalls and resets against the model.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                repeat ($urandom_range(260, 300)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
            end else if (r < 4) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b1);
            end
            d  = ($urandom_range(0, 9) < 7) ? int'(DIV) : int'($urandom_range(2, DIV + 3));
            hi = ($urandom_range(0, 1) == 0) ? d : int'($urandom_range(1, 2*d - 2));
            clr_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, d - 1)) : -1;
            period_t(d, hi, clr_at);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Checks a divided clock (clk_div) against the clk_in that produced it.
- Measures the clk_div period in clk_in cycles and declares lock after LOCK_COUNT consecutive periods equal to DIV.
- Flags loss of lock and stuck clocks with sticky errors.
- Sits beside any clock divider as a built-in self-check; its status outputs go to the status/CSR block.

Parameters:
- DIV, 3: expected clk_div period in clk_in cycles; legal range 2 .. 2**CNT_W-2.
- CNT_W, 8: width of the period counter and of the period output.
- LOCK_COUNT, 4: consecutive matching periods required to assert locked; legal range 1..15.

Ports:
- clk_in  in  1  reference clock; all logic is on posedge except the optional negedge sampler.
- reset  in  1  reset, synchronous, active-high; clock clk_in.
- clk_div  in  1  divided clock under test, sampled directly (generated from clk_in, so no synchroniser).
- err_clr  in  1  single-cycle pulse; clears the sticky errors.
- period  out  CNT_W  last measured period in clk_in cycles.
- period_valid  out  1  one-cycle pulse when period updates.
- locked  out  1  clk_div is running at DIV.
- lock_err  out  1  sticky; a mismatch occurred while locked.
- stuck_err  out  1  sticky; no clk_div rising edge within 2**CNT_W-1 cycles.
- duty_err  out  1  sticky; duty check failed (optional feature).

Behaviour:
- Reset: all outputs 0, period 0, state IDLE, cnt 0, match_cnt 0. Reset asserted mid-operation aborts everything the next edge; the sticky errors are also cleared.
- Edge detect: s_pos <= clk_div and s_pos_d <= s_pos each posedge; rise = s_pos & ~s_pos_d.
- Counter cnt:
  - Loads 1 on rise, otherwise increments.
  - Saturates at 2**CNT_W-1.
- State IDLE: wait for the first rise, which starts counting only (no period_valid). Go to ACQ.
- State ACQ:
  - On rise: period <= cnt, period_valid = 1 the following cycle.
  - If cnt == DIV, match_cnt increments, else match_cnt <= 0.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked = 1 in the same update. With LOCK_COUNT = 1, the first matching period locks.
- State LOCKED:
  - On rise with cnt == DIV: stay locked.
  - On rise with cnt != DIV: set lock_err, locked <= 0, match_cnt <= 0, go to ACQ.
- Pre-lock mismatches never set lock_err.
- Timeout: in ACQ or LOCKED, when cnt saturates without a rise:
  - Set stuck_err; locked <= 0.
  - Go to IDLE; period is unchanged.
- Simultaneous err_clr and a new error event: the error wins and stays set.
- Latency: period_valid and the lock decision come 2 clk_in cycles after the clk_div rising edge (one cycle from the sampler, one from the update).

Optional Feature:
- Macro: CLK_MON_DUTY_CHECK_EN.
- Defined:
  - A negedge sampler s_neg (synchronous reset on negedge) is added.
  - high_cnt counts, per period, the posedge samples s_pos==1 plus the negedge samples s_neg==1, i.e. high time in half-cycles.
  - On rise while LOCKED: if high_cnt != DIV, set duty_err (sticky; cleared by err_clr/reset). This is 50% duty, so odd DIV gives a high time of DIV half-cycles.
  - high_cnt restarts on each rise.
- Undefined: duty_err tied 0; no negedge logic is synthesised.

Decomposition:
- Package clk_mon_pkg holds:
  - State enum {IDLE, ACQ, LOCKED}, 2 bits.
  - Constant CNT_MAX function of CNT_W.
  - Constant MATCH_W = 4.
- Sub-module clk_div_sampler:
  - Posedge sampler and edge detect, plus the optional negedge sampler.
  - Outputs rise, s_pos, s_neg.
- Top: counter, FSM, sticky errors.

Test Plan:
- Clean divide-by-3 50%-duty stimulus, DIV=3, LOCK_COUNT=4 -> period=3 pulses every 3 cycles; locked=1 after the 4th matching period; no errors; with the macro, duty_err=0.
- After lock, insert one 4-cycle period -> lock_err=1, locked=0, re-lock after 4 further 3-cycle periods; lock_err stays 1 until err_clr, which then clears it.
- Hold clk_div at 0 after lock -> stuck_err=1 after 255 cycles with no edge, locked=0, state IDLE; restarting the clock relocks after 1+4 edges.
- Before lock, periods 3,3,2,3,3,3,3 -> no lock_err; locked asserts on the 4th consecutive 3.
- Assert reset while LOCKED with lock_err=1 -> next cycle all outputs 0; the first rise after release gives no period_valid.
- With the macro, DIV=3 clock with a high time of 1 cycle -> duty_err=1 once locked; err_clr in the same cycle as a new duty failure -> duty_err remains 1.
